dsp_diff_decoder: RTL and testbench

Inverse (decoding) filter for the team's recursive difference-equation block. That block computes y[n] = x[n] + y[n-DELAY] in modulo-2^W arithmetic. This block takes the y stream and recovers x[n] = y[n] - y[n-DELAY] with the same modulo arithmetic, so the cascade of the two blocks is the identity. It sits on the receive side of the filter chain, between a stream source and a downstream sink, and adds valid/ready flow control on both sides.

---
 rtl/dsp_diff_decoder.sv | 72 +++++++
 tb/tb_dsp_diff_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_diff_decoder.sv
// Inverse of the recursive difference-equation encoder: out = in - in[n-DELAY] mod 2^W,
// with a single-entry pass-through output register and valid/ready on both sides.
module dsp_diff_decoder #(
  parameter int W     = 8,
  parameter int DELAY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         primed
);

  localparam int CNT_W = $clog2(DELAY + 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t         state;
  logic [CNT_W-1:0] count;
  logic [W-1:0]   hist [DELAY];
  logic           accept;

  function automatic logic [W-1:0] wrap_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return a - b;
  endfunction

  // Output slot frees up in the same cycle the sink takes it.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PRIME;
      count     <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < DELAY; i++) hist[i] <= '0;
    end else if (clear) begin
      // Flush wins over a simultaneous accept; that input is discarded.
      state     <= PRIME;
      count     <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < DELAY; i++) hist[i] <= '0;
    end else begin
      if (accept) begin
        out_data  <= wrap_sub(in_data, hist[DELAY-1]);
        out_valid <= 1'b1;
        for (int i = DELAY - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= in_data;
        if (state == PRIME) begin
          if (count == CNT_W'(DELAY - 1)) begin
            state  <= RUN;
            primed <= 1'b1;
            count  <= CNT_W'(DELAY);
          end else begin
            count <= count + 1'b1;
          end
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_diff_decoder.sv
// Bench for dsp_diff_decoder: directed DELAY=2 scenarios plus a random encoder->decoder
// cascade on a DELAY=1 instance, both checked against queue-based reference models.
module tb_dsp_diff_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DELAY=2 instance
  logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_primed;
  logic [7:0] a_in_data, a_out_data;
  // DELAY=1 instance
  logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_primed;
  logic [7:0] b_in_data, b_out_data;

  dsp_diff_decoder #(.W(8), .DELAY(2)) dut_a (
    .clk(clk), .reset(reset), .clear(a_clear),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .primed(a_primed)
  );

  dsp_diff_decoder #(.W(8), .DELAY(1)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .primed(b_primed)
  );

  int total = 0;
  int bad   = 0;

  // Reference model for dut_a: every encoded sample accepted since reset/clear,
  // and the decoded samples still owed to the sink.
  logic [7:0] ys[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of dut_a: drive, sample the handshake mid-cycle, update the model at the edge.
  task automatic step(input logic vld, input logic [7:0] d, input logic ordy, input logic clr);
    logic       rdy, ov;
    logic [7:0] od, prev, x;
    a_in_valid  = vld;
    a_in_data   = d;
    a_out_ready = ordy;
    a_clear     = clr;
    @(negedge clk);
    rdy = a_in_ready;
    ov  = a_out_valid;
    od  = a_out_data;
    chk("a_in_ready", rdy, (exp_q.size() == 0) || ordy);
    chk("a_out_valid_pre", ov, exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (clr) begin
      ys.delete();
      exp_q.delete();
    end else begin
      if (ov && ordy && exp_q.size() != 0) chk("a_out_data", od, exp_q.pop_front());
      if (vld && rdy) begin
        prev = (ys.size() >= 2) ? ys[ys.size()-2] : 8'h00;
        x = d - prev;
        exp_q.push_back(x);
        ys.push_back(d);
      end
    end
    chk("a_out_valid", a_out_valid, exp_q.size() != 0);
    chk("a_primed", a_primed, ys.size() >= 2);
  endtask

  initial begin
    logic [7:0] enc [6];
    logic [7:0] held;
    logic [7:0] xq[$];
    logic [7:0] xcur, ycur, yprev, od;
    logic       rdy, ov, have;
    int         sent, recvd;

    reset = 1'b0;
    a_clear = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_clear = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    #12;
    chk("rst_a_out_data", a_out_data, 8'h00);
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_primed", a_primed, 1'b0);
    chk("rst_a_in_ready", a_in_ready, 1'b1);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;

    // Identity: encoder output for x = 1..6
    enc = '{8'd1, 8'd2, 8'd4, 8'd6, 8'd9, 8'd12};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, enc[i], 1'b1, 1'b0);
      chk("ident_data", a_out_data, i + 1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Modulo wrap
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    chk("wrap_data", a_out_data, 8'h20);

    // Backpressure: output and history frozen while the sink stalls
    step(1'b1, 8'h55, 1'b0, 1'b0);
    held = a_out_data;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h55, 1'b0, 1'b0);
      chk("bp_valid", a_out_valid, 1'b1);
      chk("bp_data", a_out_data, held);
      chk("bp_in_ready", a_in_ready, 1'b0);
    end
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("bp_after_data", a_out_data, 8'h55);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    chk("bp_after_data2", a_out_data, 8'h56);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // clear while a sample is pending and another is offered
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b1);
    chk("clr_valid", a_out_valid, 1'b0);
    chk("clr_primed", a_primed, 1'b0);
    chk("clr_in_ready", a_in_ready, 1'b1);
    step(1'b1, 8'h07, 1'b1, 1'b0);
    chk("clr_next_data", a_out_data, 8'h07);
    step(1'b1, 8'h20, 1'b1, 1'b0);

    // Asynchronous reset between edges
    #3 reset = 1'b0;
    #1;
    chk("arst_out_data", a_out_data, 8'h00);
    chk("arst_out_valid", a_out_valid, 1'b0);
    chk("arst_primed", a_primed, 1'b0);
    chk("arst_in_ready", a_in_ready, 1'b1);
    ys.delete();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b1, 8'h05, 1'b1, 1'b0);
    chk("arst_first", a_out_data, 8'h05);
    step(1'b1, 8'h05, 1'b1, 1'b0);
    chk("arst_second", a_out_data, 8'h05);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random cascade on DELAY=1: encoder y = x + y[n-1], decoder must return x
    sent = 0; recvd = 0; have = 1'b0; yprev = 8'h00; xcur = 8'h00; ycur = 8'h00;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || xq.size() != 0); cyc++) begin
      if (!have && sent < 1000) begin
        xcur = 8'($urandom);
        ycur = xcur + yprev;
        have = 1'b1;
      end
      b_in_valid  = have && ($urandom_range(0, 3) != 0);
      b_in_data   = ycur;
      b_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      rdy = b_in_ready;
      ov  = b_out_valid;
      od  = b_out_data;
      @(posedge clk);
      #1;
      if (ov && b_out_ready) begin
        if (xq.size() != 0) begin
          chk("cascade_data", od, xq.pop_front());
          recvd++;
        end else begin
          chk("cascade_spurious_valid", ov, 1'b0);
        end
      end
      if (b_in_valid && rdy) begin
        xq.push_back(xcur);
        yprev = ycur;
        sent++;
        have = 1'b0;
      end
    end
    b_in_valid = 1'b0;
    chk("cascade_count", recvd, 1000);
    chk("cascade_primed", b_primed, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
